// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave with internal word memory, independent write and read burst engines
module axi_slave_mem #(
    parameter int A_WIDTH   = 16,
    parameter int D_WIDTH   = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:0]           AWID,
    input  logic [A_WIDTH-1:0]   AWADDR,
    input  logic [3:0]           AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [8:0]           WID,
    input  logic [D_WIDTH-1:0]   WDATA,
    input  logic [D_WIDTH/8-1:0] WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [8:0]           BID,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [8:0]           ARID,
    input  logic [A_WIDTH-1:0]   ARADDR,
    input  logic [3:0]           ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [8:0]           RID,
    output logic [D_WIDTH-1:0]   RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
);

    localparam int NB = D_WIDTH / 8;
    localparam int WS = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Burst-level errors that are known as soon as the address phase is seen
    function automatic logic burst_bad(input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (burst == 2'b11) || (32'(size) > WS) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Next beat address; a wrap burst with an unsupported length steps like INCR
    function automatic logic [A_WIDTH-1:0] addr_step(input logic [A_WIDTH-1:0] addr,
                                                     input logic [3:0] len,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
        logic [A_WIDTH-1:0] incr;
        logic [A_WIDTH-1:0] mask;
        logic [A_WIDTH-1:0] res;
        logic               wrap_len_ok;
        incr        = A_WIDTH'(1) << size;
        mask        = ((A_WIDTH'(len) + A_WIDTH'(1)) << size) - A_WIDTH'(1);
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        case (burst)
            2'b01:   res = addr + incr;
            2'b10:   res = wrap_len_ok ? ((addr & ~mask) | ((addr + incr) & mask)) : (addr + incr);
            default: res = addr;
        endcase
        return res;
    endfunction

    logic [D_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_t           w_state_q, w_state_d;
    logic [8:0]         aw_id_q, aw_id_d;
    logic [A_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [3:0]         aw_len_q, aw_len_d;
    logic [2:0]         aw_size_q, aw_size_d;
    logic [1:0]         aw_burst_q, aw_burst_d;
    logic [3:0]         w_cnt_q, w_cnt_d;
    logic               w_err_q, w_err_d;
    logic               ready_en_q, ready_en_d;
    logic               mem_we;
    logic [A_WIDTH-1:0] w_idx;
    logic               w_in_range;
    logic               w_last_beat;

    r_state_t           r_state_q, r_state_d;
    logic [8:0]         ar_id_q, ar_id_d;
    logic [A_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [3:0]         ar_len_q, ar_len_d;
    logic [2:0]         ar_size_q, ar_size_d;
    logic [1:0]         ar_burst_q, ar_burst_d;
    logic [3:0]         r_cnt_q, r_cnt_d;
    logic               r_err_q, r_err_d;
    logic [A_WIDTH-1:0] r_idx;
    logic               r_in_range;
    logic               r_last_beat;

    // ready_en keeps the address channels closed on the cycle right after reset
    assign ready_en_d  = 1'b1;
    assign w_idx       = aw_addr_q >> WS;
    assign w_in_range  = 32'(w_idx) < MEM_DEPTH;
    assign w_last_beat = (w_cnt_q == aw_len_q);
    assign r_idx       = ar_addr_q >> WS;
    assign r_in_range  = 32'(r_idx) < MEM_DEPTH;
    assign r_last_beat = (r_cnt_q == ar_len_q);

    assign AWREADY = ready_en_q && (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = aw_id_q;
    assign BRESP   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;

    assign ARREADY = ready_en_q && (r_state_q == R_IDLE);
    assign RVALID  = (r_state_q == R_DATA);
    assign RID     = ar_id_q;
    assign RLAST   = (r_state_q == R_DATA) && r_last_beat;
    assign RDATA   = ((r_state_q == R_DATA) && r_in_range) ? mem_q[r_idx[IW-1:0]] : '0;
    assign RRESP   = ((r_state_q == R_DATA) && (r_err_q || !r_in_range)) ? 2'b10 : 2'b00;

    // Write burst engine: address capture, beat acceptance, response hold
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    aw_id_d    = AWID;
                    aw_addr_d  = AWADDR;
                    aw_len_d   = AWLEN;
                    aw_size_d  = AWSIZE;
                    aw_burst_d = AWBURST;
                    w_cnt_d    = 4'd0;
                    w_err_d    = burst_bad(AWLEN, AWSIZE, AWBURST);
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    mem_we = w_in_range;
                    if (!w_in_range || (WID != aw_id_q) || (WLAST != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        aw_addr_d = addr_step(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                        w_cnt_d   = w_cnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read burst engine: address capture and beat advance on each accepted beat
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_err_d    = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    ar_id_d    = ARID;
                    ar_addr_d  = ARADDR;
                    ar_len_d   = ARLEN;
                    ar_size_d  = ARSIZE;
                    ar_burst_d = ARBURST;
                    r_cnt_d    = 4'd0;
                    r_err_d    = burst_bad(ARLEN, ARSIZE, ARBURST);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        ar_addr_d = addr_step(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
                        r_cnt_d   = r_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // Control state registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            r_err_q    <= r_err_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Storage: byte-lane writes, never cleared by reset; reads see the pre-write word
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) begin
                    mem_q[w_idx[IW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - randomized self-checking bench for axi_slave_mem against a burst-level memory model
module tb_axi_slave_mem;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  AWID;
    logic [15:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [8:0]  WID;
    logic [15:0] WDATA;
    logic [1:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [8:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic [8:0]  ARID;
    logic [15:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [8:0]  RID;
    logic [15:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;

    always #5 clk = ~clk;

    axi_slave_mem #(.A_WIDTH(16), .D_WIDTH(16), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] model [DEPTH];
    logic [15:0] wdata_a [16];
    logic [1:0]  wstrb_a [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte address of beat k, written directly from the burst-type definitions
    function automatic logic [15:0] beat_addr(input int start, input int len, input int size,
                                              input int burst, input int k);
        int inc, win, base, a;
        inc = 1 << size;
        if (burst == 0) begin
            a = start;
        end else if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            win  = (len + 1) * inc;
            base = (start / win) * win;
            a    = base + ((start - base + k * inc) % win);
        end else begin
            a = start + k * inc;
        end
        return 16'(a);
    endfunction

    function automatic bit static_bad(input int len, input int size, input int burst);
        return (burst == 3) || (size > WS) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic do_write(input logic [8:0] id, input int addr, input int len, input int size,
                            input int burst, input int bad_last, input int bad_id, input int b_delay);
        bit exp_err;
        int tmo;
        int idx;
        logic [15:0] a;
        exp_err = static_bad(len, size, burst);
        @(negedge clk);
        AWID = id; AWADDR = 16'(addr); AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        AWVALID = 1'b1;
        tmo = 0;
        while (!AWREADY && tmo < 50) begin @(negedge clk); tmo++; end
        check_eq("aw_ready", 32'(AWREADY), 1);
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int k = 0; k <= len; k++) begin
            WVALID = 1'b0;
            if ($urandom_range(3) == 0) @(negedge clk);
            a   = beat_addr(addr, len, size, burst, k);
            idx = int'(a) >> WS;
            WID    = (k == bad_id) ? (id ^ 9'h001) : id;
            WDATA  = wdata_a[k];
            WSTRB  = wstrb_a[k];
            WLAST  = (k == len) || (k == bad_last);
            WVALID = 1'b1;
            tmo = 0;
            while (!WREADY && tmo < 50) begin @(negedge clk); tmo++; end
            check_eq("w_ready", 32'(WREADY), 1);
            @(posedge clk);
            if (idx < DEPTH) begin
                if (wstrb_a[k][0]) model[idx][7:0]  = wdata_a[k][7:0];
                if (wstrb_a[k][1]) model[idx][15:8] = wdata_a[k][15:8];
            end else begin
                exp_err = 1'b1;
            end
            if (k == bad_id || k == bad_last) exp_err = 1'b1;
            @(negedge clk);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        BREADY = 1'b0;
        tmo = 0;
        while (!BVALID && tmo < 50) begin @(negedge clk); tmo++; end
        check_eq("b_valid", 32'(BVALID), 1);
        for (int i = 0; i < b_delay; i++) begin
            @(negedge clk);
            check_eq("b_hold_valid", 32'(BVALID), 1);
            check_eq("b_hold_id", 32'(BID), 32'(id));
            check_eq("b_hold_resp", 32'(BRESP), exp_err ? 2 : 0);
        end
        BREADY = 1'b1;
        check_eq("bid", 32'(BID), 32'(id));
        check_eq("bresp", 32'(BRESP), exp_err ? 2 : 0);
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0;
        check_eq("b_done", 32'(BVALID), 0);
        check_eq("aw_ready_after_b", 32'(AWREADY), 1);
    endtask

    // mode 0: always ready, 1: toggle every cycle, 2: random
    task automatic do_read(input logic [8:0] id, input int addr, input int len, input int size,
                           input int burst, input int mode, input bit chk_data);
        int tmo, k, idx;
        bit sbad, inr;
        logic rr;
        logic [15:0] a;
        sbad = static_bad(len, size, burst);
        @(negedge clk);
        ARID = id; ARADDR = 16'(addr); ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        ARVALID = 1'b1;
        tmo = 0;
        while (!ARREADY && tmo < 50) begin @(negedge clk); tmo++; end
        check_eq("ar_ready", 32'(ARREADY), 1);
        @(posedge clk);
        @(negedge clk);
        ARVALID = 1'b0;
        k = 0; tmo = 0; rr = 1'b0;
        while (k <= len && tmo < 400) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = ~rr;
                default: rr = 1'($urandom_range(1));
            endcase
            RREADY = rr;
            a   = beat_addr(addr, len, size, burst, k);
            idx = int'(a) >> WS;
            inr = (idx < DEPTH);
            check_eq("r_valid", 32'(RVALID), 1);
            check_eq("r_id", 32'(RID), 32'(id));
            check_eq("r_last", 32'(RLAST), (k == len) ? 1 : 0);
            check_eq("r_resp", 32'(RRESP), (sbad || !inr) ? 2 : 0);
            if (chk_data) check_eq("r_data", 32'(RDATA), inr ? 32'(model[idx]) : 0);
            if (rr) k++;
            @(negedge clk);
            tmo++;
        end
        RREADY = 1'b0;
        check_eq("r_beats", k, len + 1);
        check_eq("r_idle", 32'(RVALID), 0);
    endtask

    task automatic rand_data(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            wdata_a[i] = 16'($urandom);
            wstrb_a[i] = full ? 2'b11 : 2'($urandom_range(3));
        end
    endtask

    initial begin
        int len, size, burst, addr;
        logic [8:0] id;
        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_awready", 32'(AWREADY), 0);
        check_eq("rst_arready", 32'(ARREADY), 0);
        check_eq("rst_wready", 32'(WREADY), 0);
        check_eq("rst_bvalid", 32'(BVALID), 0);
        check_eq("rst_rvalid", 32'(RVALID), 0);
        check_eq("rst_rlast", 32'(RLAST), 0);
        check_eq("rst_ids", 32'({BID, RID}), 0);
        check_eq("rst_resps", 32'({BRESP, RRESP}), 0);
        check_eq("rst_rdata", 32'(RDATA), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_awready", 32'(AWREADY), 1);
        check_eq("post_rst_arready", 32'(ARREADY), 1);

        // fill every word so later reads have defined contents
        for (int b = 0; b < DEPTH / 16; b++) begin
            rand_data(16, 1'b1);
            do_write(9'(b), b * 32, 15, 1, 1, -1, -1, 0);
        end

        // INCR write and readback
        wdata_a[0] = 16'hA0A1; wdata_a[1] = 16'hA1A2; wdata_a[2] = 16'hA2A3; wdata_a[3] = 16'hA3A4;
        for (int i = 0; i < 4; i++) wstrb_a[i] = 2'b11;
        do_write(9'h13A, 16'h0010, 3, 1, 1, -1, -1, 0);
        do_read(9'h0B5, 16'h0010, 3, 1, 1, 0, 1'b1);

        // WRAP read, legal and illegal length
        do_read(9'h011, 16'h001C, 3, 1, 2, 0, 1'b1);
        do_read(9'h012, 16'h001C, 2, 1, 2, 0, 1'b0);

        // partial strobe and FIXED burst
        wdata_a[0] = 16'h1234; wstrb_a[0] = 2'b11;
        do_write(9'h021, 16'h0030, 0, 1, 1, -1, -1, 0);
        wdata_a[0] = 16'hFFFF; wstrb_a[0] = 2'b01;
        do_write(9'h022, 16'h0030, 0, 1, 1, -1, -1, 0);
        check_eq("strb_merge_model", 32'(model[16'h0030 >> WS]), 32'h12FF);
        do_read(9'h023, 16'h0030, 0, 1, 1, 0, 1'b1);
        rand_data(4, 1'b1);
        do_write(9'h024, 16'h0020, 3, 1, 0, -1, -1, 0);
        do_read(9'h025, 16'h0020, 0, 1, 1, 0, 1'b1);

        // backpressure on B and R
        rand_data(8, 1'b0);
        do_write(9'h031, 16'h0080, 7, 1, 1, -1, -1, 5);
        do_read(9'h032, 16'h0080, 7, 1, 1, 1, 1'b1);

        // error bursts
        rand_data(4, 1'b1);
        do_write(9'h041, DEPTH * 2, 0, 1, 1, -1, -1, 0);
        do_read(9'h042, DEPTH * 2, 0, 1, 1, 0, 1'b1);
        do_write(9'h043, 16'h0050, 3, 1, 1, 1, -1, 0);
        do_write(9'h044, 16'h0058, 3, 1, 1, -1, 2, 0);
        do_write(9'h045, 16'h0070, 0, 1, 3, -1, -1, 0);
        do_write(9'h046, 16'hFFFE, 1, 1, 1, -1, -1, 0);
        do_read(9'h047, 16'hFFFE, 1, 1, 1, 0, 1'b1);
        do_read(9'h048, 16'h0050, 3, 1, 1, 2, 1'b1);

        // reset in the middle of concurrent write and read bursts
        @(negedge clk);
        AWID = 9'h005; AWADDR = 16'h0040; AWLEN = 4'd3; AWSIZE = 3'd1; AWBURST = 2'd1; AWVALID = 1'b1;
        ARID = 9'h006; ARADDR = 16'h0060; ARLEN = 4'd3; ARSIZE = 3'd1; ARBURST = 2'd1; ARVALID = 1'b1;
        check_eq("mid_awready", 32'(AWREADY), 1);
        check_eq("mid_arready", 32'(ARREADY), 1);
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0; ARVALID = 1'b0;
        WID = 9'h005; WDATA = 16'hBEE0; WSTRB = 2'b11; WLAST = 1'b0; WVALID = 1'b1; RREADY = 1'b1;
        check_eq("mid_wready", 32'(WREADY), 1);
        check_eq("mid_rdata0", 32'(RDATA), 32'(model[16'h0060 >> WS]));
        @(posedge clk);
        model[16'h0040 >> WS] = 16'hBEE0;
        @(negedge clk);
        WDATA = 16'hBEE1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mrst_awready", 32'(AWREADY), 0);
        check_eq("mrst_arready", 32'(ARREADY), 0);
        check_eq("mrst_wready", 32'(WREADY), 0);
        check_eq("mrst_bvalid", 32'(BVALID), 0);
        check_eq("mrst_rvalid", 32'(RVALID), 0);
        check_eq("mrst_rlast", 32'(RLAST), 0);
        check_eq("mrst_ids", 32'({BID, RID}), 0);
        check_eq("mrst_resps", 32'({BRESP, RRESP}), 0);
        check_eq("mrst_rdata", 32'(RDATA), 0);
        rst = 1'b0; WVALID = 1'b0; RREADY = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mrel_awready", 32'(AWREADY), 1);
        check_eq("mrel_arready", 32'(ARREADY), 1);
        repeat (3) begin
            check_eq("mrel_no_b", 32'(BVALID), 0);
            check_eq("mrel_no_r", 32'(RVALID), 0);
            @(negedge clk);
        end
        do_read(9'h007, 16'h0040, 1, 1, 1, 0, 1'b1);

        // randomized bursts against the model
        for (int it = 0; it < 40; it++) begin
            id    = 9'($urandom);
            burst = $urandom_range(2);
            size  = ($urandom_range(7) == 0) ? 2 : $urandom_range(1);
            if (burst == 2) begin
                case ($urandom_range(3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(15);
            end
            addr = $urandom_range(16'h021F) & ~((1 << size) - 1);
            rand_data(len + 1, 1'b0);
            do_write(id, addr, len, size, burst, -1, -1, $urandom_range(3));
            do_read(id ^ 9'h100, addr, len, size, burst, 2, 1'b1);
            do_read(9'($urandom), $urandom_range(16'h01FF) & ~1, $urandom_range(15), 1, 1,
                    $urandom_range(2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
